// File: rtl/multi_port_mem_behavioral.sv
// Generic multi-port storage: per-port writes with byte enables and deterministic
// priority, optional write-first bypass, and optional registered read ports with hold.
module multi_port_mem_behavioral #(
   parameter int DATAW      = 32,
   parameter int SIZE       = 64,
   parameter int NUM_RPORTS = 2,
   parameter int NUM_WPORTS = 1,
   parameter int OUT_REG    = 0,
   parameter int BYPASS     = 0,
   parameter int BYTEEN     = 0,
   parameter int ADDRW      = (SIZE > 1) ? $clog2(SIZE) : 1,
   parameter int BYTEW      = (BYTEEN != 0) ? DATAW / 8 : 1
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic [NUM_WPORTS-1:0]         wren_i,
   input  logic [NUM_WPORTS*ADDRW-1:0]   waddr_i,
   input  logic [NUM_WPORTS*DATAW-1:0]   wdata_i,
   input  logic [NUM_WPORTS*BYTEW-1:0]   wbyteen_i,
   input  logic [NUM_RPORTS-1:0]         rden_i,
   input  logic [NUM_RPORTS*ADDRW-1:0]   raddr_i,
   output logic [NUM_RPORTS*DATAW-1:0]   rdata_o
);

   localparam int NLANES = (BYTEEN != 0) ? DATAW / 8 : 1;
   localparam int LANEW  = DATAW / NLANES;
   localparam logic [ADDRW:0] SIZE_W = (ADDRW + 1)'(SIZE);

   logic [DATAW-1:0]                  mem_r [SIZE];
   logic [NUM_RPORTS-1:0][DATAW-1:0]  rd_val_s;

   function automatic logic in_range(input logic [ADDRW-1:0] addr);
      return ({1'b0, addr} < SIZE_W);
   endfunction

   // Word as it will look after this edge: ports applied in ascending order so the
   // highest-indexed port wins each byte independently.
   function automatic logic [DATAW-1:0] merge_word(
      input logic [DATAW-1:0]              old_word,
      input logic [ADDRW-1:0]              addr,
      input logic [NUM_WPORTS-1:0]         wren,
      input logic [NUM_WPORTS*ADDRW-1:0]   waddr,
      input logic [NUM_WPORTS*DATAW-1:0]   wdata,
      input logic [NUM_WPORTS*BYTEW-1:0]   wbyteen
   );
      logic [DATAW-1:0] word;
      word = old_word;
      for (int p = 0; p < NUM_WPORTS; p++) begin
         if (wren[p] && (waddr[p*ADDRW +: ADDRW] == addr)) begin
            for (int b = 0; b < NLANES; b++) begin
               if ((BYTEEN == 0) || wbyteen[p*BYTEW + b]) begin
                  word[b*LANEW +: LANEW] = wdata[p*DATAW + b*LANEW +: LANEW];
               end else begin
                  word[b*LANEW +: LANEW] = word[b*LANEW +: LANEW];
               end
            end
         end else begin
            word = word;
         end
      end
      return word;
   endfunction

   // Storage update; reset clears every word and drops same-cycle writes
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < SIZE; i++) begin
            mem_r[i] <= '0;
         end
      end else begin
         for (int p = 0; p < NUM_WPORTS; p++) begin
            if (wren_i[p] && in_range(waddr_i[p*ADDRW +: ADDRW])) begin
               mem_r[waddr_i[p*ADDRW +: ADDRW]] <= merge_word(
                  mem_r[waddr_i[p*ADDRW +: ADDRW]], waddr_i[p*ADDRW +: ADDRW],
                  wren_i, waddr_i, wdata_i, wbyteen_i);
            end
         end
      end
   end

   // Per-port read value, forwarding same-cycle writes when bypass is on
   always_comb begin
      for (int r = 0; r < NUM_RPORTS; r++) begin
         rd_val_s[r] = '0;
         if (in_range(raddr_i[r*ADDRW +: ADDRW])) begin
            if (BYPASS != 0) begin
               rd_val_s[r] = merge_word(mem_r[raddr_i[r*ADDRW +: ADDRW]],
                                        raddr_i[r*ADDRW +: ADDRW],
                                        wren_i, waddr_i, wdata_i, wbyteen_i);
            end else begin
               rd_val_s[r] = mem_r[raddr_i[r*ADDRW +: ADDRW]];
            end
         end else begin
            rd_val_s[r] = '0;
         end
      end
   end

   if (OUT_REG != 0) begin : g_out_reg
      logic [NUM_RPORTS-1:0][DATAW-1:0] rdata_r;

      // Output registers load only on rden and otherwise hold indefinitely
      always_ff @(posedge clk_i) begin
         for (int r = 0; r < NUM_RPORTS; r++) begin
            if (rst_i) begin
               rdata_r[r] <= '0;
            end else if (rden_i[r]) begin
               rdata_r[r] <= rd_val_s[r];
            end else begin
               rdata_r[r] <= rdata_r[r];
            end
         end
      end

      assign rdata_o = rdata_r;
   end else begin : g_out_comb
      logic unused_rden_s;
      assign unused_rden_s = ^rden_i;
      assign rdata_o       = rd_val_s;
   end

endmodule
